// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
// The widths match the board's 256Kx16 asynchronous SRAM.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER
    } state_e;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } cmd_t;

    function automatic logic [SRAM_DATA_W-1:0] lane_mask(
        input logic [SRAM_DATA_W-1:0] d,
        input logic [1:0]             be
    );
        logic [SRAM_DATA_W-1:0] m;
        m = '0;
        if (be[0]) m[SRAM_DATA_W/2-1:0] = d[SRAM_DATA_W/2-1:0];
        if (be[1]) m[SRAM_DATA_W-1:SRAM_DATA_W/2] = d[SRAM_DATA_W-1:SRAM_DATA_W/2];
        return m;
    endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Round-robin arbiter: the pointer names the first port searched.
// Combinational; the caller owns and advances the pointer.
module sram_rr_arb #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                idx = (int'(ptr_i) + i) % N;
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for the async SRAM.
// Each transaction: IDLE grant, ACCESS x(WAIT_CYCLES+1), RECOVER with ACK.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    input  logic [1:0]        BE0,
    input  logic [1:0]        BE1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [DATA_W-1:0] RDATA,
    output logic              BUSY,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_DQ_O,
    output logic              SRAM_DQ_OE,
    input  logic [DATA_W-1:0] SRAM_DQ_I,
    output logic              SRAM_CE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N
);

    localparam logic [3:0] WLAST = 4'(WAIT_CYCLES);

    state_e            state_q;
    cmd_t              cmd_q, cmd_d;
    logic              port_q;
    logic              ptr_q;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic              ce_n_q, we_n_q, oe_n_q, lb_n_q, ub_n_q;
    logic              dq_oe_q;
    logic [1:0]        gnt;

    sram_rr_arb #(.N(2)) u_arb (
        .req_i ({REQ1, REQ0}),
        .en_i  (state_q == IDLE),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        cmd_d = '0;
        if (gnt[1]) begin
            cmd_d.we    = WE1;
            cmd_d.addr  = ADDR1;
            cmd_d.wdata = WDATA1;
            cmd_d.be    = BE1;
        end else begin
            cmd_d.we    = WE0;
            cmd_d.addr  = ADDR0;
            cmd_d.wdata = WDATA0;
            cmd_d.be    = BE0;
        end
    end

    assign cnt_d = cnt_q + 4'd1;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            port_q  <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        state_q <= ACCESS;
                        cmd_q   <= cmd_d;
                        port_q  <= gnt[1];
                        ptr_q   <= !gnt[1];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ce_n_q  <= 1'b0;
                        lb_n_q  <= !cmd_d.be[0];
                        ub_n_q  <= !cmd_d.be[1];
                        we_n_q  <= !cmd_d.we;
                        oe_n_q  <= cmd_d.we;
                        dq_oe_q <= cmd_d.we;
                    end
                end
                ACCESS: begin
                    if (cnt_q == WLAST) begin
                        state_q       <= RECOVER;
                        ce_n_q        <= 1'b1;
                        we_n_q        <= 1'b1;
                        oe_n_q        <= 1'b1;
                        lb_n_q        <= 1'b1;
                        ub_n_q        <= 1'b1;
                        dq_oe_q       <= 1'b0;
                        ack_q[port_q] <= 1'b1;
                        if (!cmd_q.we) rdata_q <= lane_mask(SRAM_DQ_I, cmd_q.be);
                    end else begin
                        cnt_q <= cnt_d;
                        // final ACCESS cycle holds data/address with WE_N high
                        if (cnt_d == WLAST) we_n_q <= 1'b1;
                    end
                end
                RECOVER: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ACK0       = ack_q[0];
    assign ACK1       = ack_q[1];
    assign RDATA      = rdata_q;
    assign BUSY       = busy_q;
    assign SRAM_ADDR  = cmd_q.addr;
    assign SRAM_DQ_O  = cmd_q.wdata;
    assign SRAM_DQ_OE = dq_oe_q;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_LB_N  = lb_n_q;
    assign SRAM_UB_N  = ub_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized + directed bench for sram_arbiter with a behavioural
// SRAM and a transaction-level reference memory.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [17:0] addr0 = '0, addr1 = '0;
    logic [15:0] wd0 = '0, wd1 = '0;
    logic [1:0]  be0 = '0, be1 = '0;
    logic        ack0, ack1, busy, dqoe, ce_n, we_n, oe_n, lb_n, ub_n;
    logic [15:0] rdata, dqo, dqi;
    logic [17:0] sa;

    logic        b_req0 = 0, b_we0 = 0;
    logic [17:0] b_addr0 = '0;
    logic [15:0] b_wd0 = '0;
    logic [1:0]  b_be0 = '0;
    logic        b_ack0, b_ack1, b_busy, b_dqoe;
    logic        b_ce_n, b_we_n, b_oe_n, b_lb_n, b_ub_n;
    logic [15:0] b_rdata, b_dqo;
    logic [17:0] b_sa;

    logic [15:0] smem [0:255];
    logic [15:0] ref_mem [0:255];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .CLOCK(clk), .RESET_N(rst_n),
        .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wd0), .WDATA1(wd1),
        .BE0(be0), .BE1(be1), .ACK0(ack0), .ACK1(ack1),
        .RDATA(rdata), .BUSY(busy), .SRAM_ADDR(sa), .SRAM_DQ_O(dqo),
        .SRAM_DQ_OE(dqoe), .SRAM_DQ_I(dqi), .SRAM_CE_N(ce_n),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n),
        .SRAM_UB_N(ub_n)
    );

    sram_arbiter #(.WAIT_CYCLES(3)) dut_w3 (
        .CLOCK(clk), .RESET_N(rst_n),
        .REQ0(b_req0), .REQ1(1'b0), .WE0(b_we0), .WE1(1'b0),
        .ADDR0(b_addr0), .ADDR1(18'd0), .WDATA0(b_wd0), .WDATA1(16'd0),
        .BE0(b_be0), .BE1(2'b00), .ACK0(b_ack0), .ACK1(b_ack1),
        .RDATA(b_rdata), .BUSY(b_busy), .SRAM_ADDR(b_sa), .SRAM_DQ_O(b_dqo),
        .SRAM_DQ_OE(b_dqoe), .SRAM_DQ_I(16'd0), .SRAM_CE_N(b_ce_n),
        .SRAM_WE_N(b_we_n), .SRAM_OE_N(b_oe_n), .SRAM_LB_N(b_lb_n),
        .SRAM_UB_N(b_ub_n)
    );

    // behavioural async SRAM: writes lanes while CE_N/WE_N are low
    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) smem[sa[7:0]][7:0] <= dqo[7:0];
            if (!ub_n) smem[sa[7:0]][15:8] <= dqo[15:8];
        end
    end
    assign dqi = (!ce_n && !oe_n) ? smem[sa[7:0]] : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] lanes(input logic [15:0] d, input logic [1:0] be);
        return {be[1] ? d[15:8] : 8'h00, be[0] ? d[7:0] : 8'h00};
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] be);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 0;
        req1 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // one isolated transaction on port p, with strobe cycle counts
    task automatic txn(input bit p, input bit we, input logic [17:0] a,
                       input logic [15:0] d, input logic [1:0] be,
                       output int ack_cyc, output int we_lo, output int oe_hi,
                       output int ce_lo, output int ub_lo, output int lb_lo,
                       output int wrong, output logic [15:0] rd);
        ack_cyc = 0; we_lo = 0; oe_hi = 0; ce_lo = 0;
        ub_lo = 0; lb_lo = 0; wrong = 0; rd = '0;
        @(negedge clk);
        if (!p) begin we0 = we; addr0 = a; wd0 = d; be0 = be; req0 = 1; end
        else    begin we1 = we; addr1 = a; wd1 = d; be1 = be; req1 = 1; end
        for (int k = 1; k <= 30 && ack_cyc == 0; k++) begin
            @(negedge clk);
            if (!we_n) we_lo++;
            if (dqoe)  oe_hi++;
            if (!ce_n) ce_lo++;
            if (!ub_n) ub_lo++;
            if (!lb_n) lb_lo++;
            if (p ? ack0 : ack1) wrong++;
            if (p ? ack1 : ack0) begin ack_cyc = k + 1; rd = rdata; end
        end
        req0 = 0;
        req1 = 0;
        if (we && ack_cyc != 0) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, be);
    endtask

    task automatic rand_port(input bit p);
        for (int n = 0; n < 25; n++) begin
            int          gap;
            bit          got;
            bit          we;
            logic [17:0] a;
            logic [15:0] d;
            logic [1:0]  be;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            we = 1'($urandom_range(0, 1));
            a  = 18'($urandom_range(0, 15));
            d  = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            if (!p) begin we0 = we; addr0 = a; wd0 = d; be0 = be; req0 = 1; end
            else    begin we1 = we; addr1 = a; wd1 = d; be1 = be; req1 = 1; end
            got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (p ? ack1 : ack0) got = 1;
            end
            check(p ? "rand_ack1" : "rand_ack0", 32'(got), 32'd1);
            if (got && !we) check("rand_rdata", 32'(rdata), 32'(lanes(ref_mem[a[7:0]], be)));
            if (got && we) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, be);
            if (!p) req0 = 0; else req1 = 0;
        end
    endtask

    initial begin
        int ac, wl, oh, cl, ul, ll, wr;
        logic [15:0] rd;
        bit exp_port;
        int nack;
        int a0c, a1c;

        for (int i = 0; i < 256; i++) begin
            smem[i] = '0;
            ref_mem[i] = '0;
        end

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ce_n", 32'(ce_n), 32'd1);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_lbub", 32'({lb_n, ub_n}), 32'd3);
        check("rst_addr", 32'(sa), 32'd0);
        check("rst_dqo", 32'(dqo), 32'd0);
        check("rst_dqoe", 32'(dqoe), 32'd0);
        check("rst_acks", 32'({ack0, ack1}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // write A55A to 0x10
        txn(0, 1, 18'h10, 16'hA55A, 2'b11, ac, wl, oh, cl, ul, ll, wr, rd);
        check("wr_ack_cyc", 32'(ac), 32'd4);
        check("wr_we_lo", 32'(wl), 32'd1);
        check("wr_oe_hi", 32'(oh), 32'd2);
        check("wr_ce_lo", 32'(cl), 32'd2);
        check("wr_wrong_ack", 32'(wr), 32'd0);
        check("wr_mem", 32'(smem[8'h10]), 32'(ref_mem[8'h10]));

        // read back low byte only
        txn(0, 0, 18'h10, 16'h0, 2'b01, ac, wl, oh, cl, ul, ll, wr, rd);
        check("rd_ack_cyc", 32'(ac), 32'd4);
        check("rd_rdata", 32'(rd), 32'h005A);
        check("rd_ub_lo", 32'(ul), 32'd0);
        check("rd_we_lo", 32'(wl), 32'd0);
        check("rd_oe_hi", 32'(oh), 32'd0);

        // BE=00 write: no lane strobes, memory untouched, still acked
        txn(1, 1, 18'h10, 16'h1111, 2'b00, ac, wl, oh, cl, ul, ll, wr, rd);
        check("be0_ack_cyc", 32'(ac), 32'd4);
        check("be0_lanes", 32'(ul + ll), 32'd0);
        check("be0_mem", 32'(smem[8'h10]), 32'h0000A55A);

        // WAIT_CYCLES=3 write
        @(negedge clk);
        b_we0 = 1; b_addr0 = 18'h3; b_wd0 = 16'h5555; b_be0 = 2'b11; b_req0 = 1;
        cl = 0; wl = 0; ac = 0;
        for (int k = 1; k <= 20 && ac == 0; k++) begin
            @(negedge clk);
            if (!b_ce_n) cl++;
            if (!b_we_n) wl++;
            if (b_ack0) ac = k + 1;
        end
        b_req0 = 0;
        check("w3_ce_lo", 32'(cl), 32'd4);
        check("w3_we_lo", 32'(wl), 32'd3);
        check("w3_ack_cyc", 32'(ac), 32'd6);

        // simultaneous requests from reset: alternate grants
        do_reset();
        we0 = 0; addr0 = 18'h10; be0 = 2'b11;
        we1 = 0; addr1 = 18'h3;  be1 = 2'b11;
        req0 = 1; req1 = 1;
        exp_port = 0;
        nack = 0;
        for (int k = 1; k <= 40 && nack < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                nack++;
                check("rr_port", 32'(ack1), 32'(exp_port));
                check("rr_cycle", 32'(k + 1), 32'(4 * nack));
                check("rr_rdata", 32'(rdata), 32'(exp_port ? ref_mem[3] : ref_mem[16]));
                exp_port = !exp_port;
                if (nack == 4) begin req0 = 0; req1 = 0; end
            end
        end
        check("rr_acks", 32'(nack), 32'd4);
        req0 = 0;
        req1 = 0;
        @(negedge clk);

        // random traffic from both ports
        fork
            rand_port(0);
            rand_port(1);
        join
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) check("rand_mem", 32'(smem[i]), 32'(ref_mem[i]));

        // reset in the middle of a port-1 write
        @(negedge clk);
        we1 = 1; addr1 = 18'h20; wd1 = 16'h1234; be1 = 2'b11; req1 = 1;
        @(negedge clk);
        check("mid_we_n", 32'(we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1F);
        check("mid_rst_dqoe", 32'(dqoe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("mid_rst_ack", 32'({ack0, ack1}), 32'd0);
        check("mid_rst_mem", 32'(smem[8'h20]), 32'(ref_mem[8'h20]));
        rst_n = 1'b1;
        we0 = 1; addr0 = 18'h21; wd0 = 16'hBEEF; be0 = 2'b11; req0 = 1;
        a0c = 0;
        a1c = 0;
        for (int k = 1; k <= 20 && a1c == 0; k++) begin
            @(negedge clk);
            if (ack0 && a0c == 0) begin a0c = k + 1; req0 = 0; end
            if (ack1) begin a1c = k + 1; req1 = 0; end
        end
        req0 = 0;
        req1 = 0;
        ref_mem[8'h21] = 16'hBEEF;
        ref_mem[8'h20] = 16'h1234;
        check("post_rst_ack0_cyc", 32'(a0c), 32'd4);
        check("post_rst_ack1_cyc", 32'(a1c), 32'd8);
        @(negedge clk);
        check("post_rst_mem20", 32'(smem[8'h20]), 32'(ref_mem[8'h20]));
        check("post_rst_mem21", 32'(smem[8'h21]), 32'(ref_mem[8'h21]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and timing sequencer for the board's 256K×16 asynchronous SRAM. It accepts word read/write commands from two independent requesters and grants them round-robin. It drives the SRAM control strobes, address, byte lanes and data bus with fixed setup, hold and turnaround, and returns an acknowledge plus read data. It replaces direct strobe driving by pattern writers and readers. Every SRAM client connects through this block.

## Interface
- ADDR_W, 18: SRAM word-address width.
- DATA_W, 16: SRAM data width; byte lanes are [7:0] = low, [15:8] = high.
- WAIT_CYCLES, 1: extra ACCESS cycles beyond the first; legal range 1..15.

Clocking: one clock; reset is asynchronous and active-low (CLOCK, RESET_N).

- CLOCK, in, 1: sole clock, rising edge.
- RESET_N, in, 1: asynchronous active-low reset.
- REQ0 / REQ1, in, 1: command request; held high with fields stable until the matching ACK.
- WE0 / WE1, in, 1: 1 = write, 0 = read.
- ADDR0 / ADDR1, in, ADDR_W: word address.
- WDATA0 / WDATA1, in, DATA_W: write data.
- BE0 / BE1, in, 2: byte enables; bit0 = low byte, bit1 = high byte.
- ACK0 / ACK1, out, 1: one-cycle completion pulse.
- RDATA, out, DATA_W: read data, valid in the ACK cycle of a read.
- BUSY, out, 1: high whenever the state is not IDLE.
- SRAM_ADDR, out, ADDR_W: address pins.
- SRAM_DQ_O, out, DATA_W: data driven toward the SRAM.
- SRAM_DQ_OE, out, 1: tristate enable for SRAM_DQ_O; the top level builds the inout.
- SRAM_DQ_I, in, DATA_W: data read from the SRAM pins.
- SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N, out, 1 each: active-low strobes.

## Operation
- States: IDLE → ACCESS → RECOVER → IDLE. There is no other path.
- IDLE: arbitrate REQ0/REQ1 and latch the winner's WE, ADDR, WDATA and BE into the command register. If no REQ is high, remain in IDLE.
- Arbitration is round-robin. A priority pointer names the preferred port. After a grant to port n, the pointer moves to the other port. Reset sets the pointer to port 0.
- ACCESS lasts WAIT_CYCLES+1 cycles, counted by a 4-bit counter.
  - SRAM_CE_N = 0 for the whole state.
  - SRAM_ADDR holds the latched address for the whole state.
  - SRAM_LB_N = !BE[0] and SRAM_UB_N = !BE[1].
- Write in ACCESS:
  - SRAM_DQ_OE = 1 and SRAM_DQ_O = WDATA for all ACCESS cycles.
  - SRAM_WE_N = 0 for all ACCESS cycles except the last. That final cycle is the data/address hold cycle.
  - SRAM_OE_N = 1.
- Read in ACCESS:
  - SRAM_OE_N = 0, SRAM_WE_N = 1, SRAM_DQ_OE = 0.
  - SRAM_DQ_I is registered on the last ACCESS cycle.
  - Bytes whose BE bit is 0 are forced to 0 in RDATA.
- RECOVER (1 cycle):
  - All strobes return to inactive and SRAM_DQ_OE = 0 (bus turnaround).
  - The granted ACK pulses, and RDATA is updated for reads.
  - RDATA holds its value until the next read completes.
- BE = 00 runs the full sequence with both lane strobes inactive, then acknowledges normally.
- A requester may drop REQ only after seeing ACK. A REQ dropped before its grant is simply not served. A REQ dropped after its grant does not abort the access.

## Timing
- Every transaction takes WAIT_CYCLES+3 cycles (4 at default): IDLE grant, ACCESS ×(W+1), RECOVER with ACK.
- Arbitration is never done in RECOVER. The just-acknowledged REQ is still high in that cycle and must not be granted again. Back-to-back commands from one port are therefore spaced W+3 cycles apart.
- Simultaneous REQ0 and REQ1 in IDLE: the port named by the pointer wins. The other port is served in the next transaction.
- All outputs are registered; strobes change only on CLOCK rising edges.
- Reset values: SRAM_CE_N = SRAM_WE_N = SRAM_OE_N = SRAM_LB_N = SRAM_UB_N = 1; SRAM_ADDR = 0; SRAM_DQ_O = 0; SRAM_DQ_OE = 0; ACK0 = ACK1 = 0; RDATA = 0; BUSY = 0; state = IDLE; pointer = port 0; counter = 0.
- Reset asserted mid-ACCESS: all strobes go inactive immediately (asynchronously) and no ACK is issued. The requester must re-issue the command.

## Structure
- Package sram_pkg holds:
  - the state enum (IDLE, ACCESS, RECOVER);
  - SRAM_ADDR_W and SRAM_DATA_W constants;
  - a command struct {we, addr, wdata, be}.
- Sub-module sram_rr_arb is a 2-way round-robin arbiter (request vector, enable and pointer in; one-hot grant out). It is reused later for wider requester counts.
- The top-level pin wrapper owns the inout DQ. This block has no bidirectional ports.

## Test plan
- Port 0 writes 0xA55A to address 0x00010 with BE = 11 → WE_N low for exactly 1 cycle, DQ_OE high for 2 cycles, ACK0 on cycle 4.
- Read back 0x00010 with SRAM model data 0xA55A, BE = 01 → RDATA = 0x005A in the ACK0 cycle; UB_N stays 1 throughout.
- REQ0 and REQ1 raised together and held for 4 transactions → grant order 0, 1, 0, 1 with ACKs every 4 cycles.
- WAIT_CYCLES = 3 write → CE_N low for 4 cycles, WE_N low for 3; transaction takes 6 cycles.
- RESET_N pulsed low during ACCESS of a write → strobes inactive that same cycle, no ACK, BUSY = 0; the subsequent request completes normally with port 0 preferred.
- BE = 00 write → LB_N = UB_N = 1 throughout, model memory unchanged, ACK still issued.
